bcd_conv_sched: RTL
===================

Name: bcd_conv_sched

Overview:
Time-shares one bin_bcd converter (8-bit binary in, two-digit packed BCD out, no done flag) between N requesters, e.g. seconds/minutes/hours counters of the data clock. Each requester posts a binary value with a one-cycle pulse. The scheduler latches it, arbitrates round-robin, issues din_vld/bin_in to the converter and times the fixed converter latency. It then captures bcd_out into that channel's result register and pulses a per-channel valid.

Parameters:
N, 3, number of requester channels (2..8)
CONV_LAT, 10, cycles from conv_vld assertion to the cycle in which conv_bcd holds the valid result
MAXV, 99, largest value representable by the converter; larger inputs are clamped

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req  in  N  per-channel one-cycle request pulse
req_bin  in  8*N  per-channel binary value, channel i at [8i+7:8i], sampled when req[i]=1
conv_vld  out  1  one-cycle start pulse to converter din_vld
conv_bin  out  8  value to converter bin_in, valid when conv_vld=1
conv_bcd  in  8  converter bcd_out
bcd_all  out  8*N  per-channel latest BCD result, channel i at [8i+7:8i]
res_vld  out  N  one-cycle pulse, bit i set in the cycle bcd_all channel i updates
ovf  out  N  one-cycle pulse alongside res_vld[i] when that conversion was clamped
busy  out  1  1 while state is not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, pending=0, hold regs=0, rr pointer=0, latency counter=0. bcd_all=0, res_vld=0, ovf=0, conv_vld=0, conv_bin=0, busy=0.
- Reset mid-conversion: the conversion is abandoned with no res_vld, and all pending requests are lost. The converter shares rst_n.
- Capture: req[i]=1 -> hold[i]<=req_bin[i], pend[i]<=1, clamp flag c[i]<=(req_bin[i]>MAXV). A repeat req while pending overwrites the value (latest wins), and still only one conversion runs.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE: if pend!=0, choose the first set bit at or after ptr, cyclically. Latch sel, go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): conv_vld=1, conv_bin = c[sel] ? MAXV : hold[sel]. Clear pend[sel] and latch the clamp flag. If req[sel] fires in this same cycle, pend[sel] stays 1 (new request wins) and the new data goes to hold only. The value already issued is unaffected. ptr<=(sel+1) mod N. Load counter=CONV_LAT-1, go to WAIT.
- WAIT: counter decrements each cycle. At counter==0, go to CAPTURE.
- CAPTURE (1 cycle, at cycle T+CONV_LAT where T is the ISSUE cycle): register conv_bcd into bcd_all[sel]. res_vld[sel] and ovf[sel] (if clamped) pulse in cycle T+CONV_LAT+1, coincident with the new bcd_all value. Go to IDLE.
- Minimum spacing between conv_vld pulses is CONV_LAT+2 cycles. conv_vld is never asserted while a conversion is in flight.
- conv_bin holds its last value outside ISSUE. Other channels' bcd_all entries are never disturbed.
- Fairness: with all channels continuously pending, grants go 0,1,...,N-1,0,... Worst-case wait for any channel is N*(CONV_LAT+2) cycles.
- busy=1 in ISSUE, WAIT and CAPTURE.
- res_vld is one-hot or zero.

Test Plan:
- Single request: req[0] with value 8'd59 in cycle 0 -> conv_vld and conv_bin=59 in cycle 2. bcd_all[7:0]=8'h59 and res_vld=3'b001 in cycle 2+CONV_LAT+1. ovf=0.
- All three channels requested in the same cycle with 7, 45 and 23 -> issue order is ch0, ch1, ch2, each CONV_LAT+2 apart. Final bcd_all={8'h23,8'h45,8'h07}, with three separate res_vld pulses.
- Clamp: req[2] with value 8'd150 -> conv_bin=99, bcd_all[23:16]=8'h99, res_vld[2] and ovf[2] pulse together.
- Overwrite and re-request: req[1] value 10, then req[1] value 12 while ch0 is converting -> exactly one ch1 conversion, result 8'h12. A req[1] with value 30 in ch1's ISSUE cycle -> a second ch1 conversion yielding 8'h30.
- Round-robin: ch0 and ch2 held continuously pending -> grants alternate 0,2,0,2. ch0 is never granted twice in a row.
- Reset mid-WAIT: drop rst_n for one cycle while ch1 is converting -> no res_vld, bcd_all=0, busy=0, pend=0. A subsequent single request converts normally.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin scheduler time-sharing one fixed-latency bin-to-BCD converter
module bcd_conv_sched #(
    parameter int N        = 3,
    parameter int CONV_LAT = 10,
    parameter int MAXV     = 99
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_bin,
    output logic           conv_vld,
    output logic [7:0]     conv_bin,
    input  logic [7:0]     conv_bcd,
    output logic [8*N-1:0] bcd_all,
    output logic [N-1:0]   res_vld,
    output logic [N-1:0]   ovf,
    output logic           busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(CONV_LAT + 1);
    localparam logic [7:0] MAXV8 = 8'(MAXV);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t        state_q;
    logic [N-1:0]  pend_q, clamp_q, res_vld_q, ovf_q;
    logic [7:0]    hold_q [N];
    logic [7:0]    bcd_q  [N];
    logic [7:0]    req_v  [N];
    logic [PW-1:0] ptr_q, sel_q;
    logic [CW-1:0] cnt_q;
    logic          sel_clamp_q, conv_vld_q;
    logic [7:0]    conv_bin_q;

    logic          found_d, clamp_d;
    logic [PW-1:0] sel_d, cand;
    logic [7:0]    val_d;

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign req_v[g]             = req_bin[8*g +: 8];
        assign bcd_all[8*g +: 8]    = bcd_q[g];
    end

    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!found_d && pend_q[cand]) begin
                found_d = 1'b1;
                sel_d   = cand;
            end
        end
        // A re-request landing in the grant cycle is forwarded so the issued value is the newest
        if (req[sel_d]) begin
            val_d   = req_v[sel_d];
            clamp_d = req_v[sel_d] > MAXV8;
        end else begin
            val_d   = hold_q[sel_d];
            clamp_d = clamp_q[sel_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            clamp_q     <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            sel_clamp_q <= 1'b0;
            conv_vld_q  <= 1'b0;
            conv_bin_q  <= '0;
            res_vld_q   <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
                bcd_q[i]  <= '0;
            end
        end else begin
            conv_vld_q <= 1'b0;
            res_vld_q  <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    hold_q[i]  <= req_v[i];
                    clamp_q[i] <= req_v[i] > MAXV8;
                    pend_q[i]  <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        sel_q       <= sel_d;
                        sel_clamp_q <= clamp_d;
                        conv_vld_q  <= 1'b1;
                        conv_bin_q  <= clamp_d ? MAXV8 : val_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!req[sel_q]) pend_q[sel_q] <= 1'b0;
                    ptr_q   <= (sel_q == PW'(N - 1)) ? '0 : sel_q + 1'b1;
                    cnt_q   <= CW'(CONV_LAT - 1);
                    state_q <= (CONV_LAT > 1) ? WAIT : CAPTURE;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q <= CW'(1)) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    bcd_q[sel_q]     <= conv_bcd;
                    res_vld_q[sel_q] <= 1'b1;
                    ovf_q[sel_q]     <= sel_clamp_q;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_vld = conv_vld_q;
    assign conv_bin = conv_bin_q;
    assign res_vld  = res_vld_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q != IDLE);
endmodule
